// File: rtl/weight_loader_if.sv
// Weight FIFO write-side bus between weight_loader (master) and the weight FIFO (slave).
// request is the FIFO's request_data (write_en & ~full); sending_data/data present the
// loader's buffer head, which the FIFO takes whenever request and sending_data are both high.
interface weight_loader_if #(
    parameter int ARRAY_W = 32,
    parameter int DATA_W  = 8
);
    logic                      write_en;
    logic                      request;
    logic                      sending_data;
    logic [ARRAY_W*DATA_W-1:0] data;

    modport master (
        output write_en,
        output sending_data,
        output data,
        input  request
    );

    modport slave (
        input  write_en,
        input  sending_data,
        input  data,
        output request
    );
endinterface

// File: rtl/weight_loader.sv
// weight_loader: streams num_rows weight rows from the weight BRAM into the weight FIFO.
// A 2-entry buffer absorbs the 1-cycle BRAM read latency so one row per cycle is sustained.
// Optional feature: define WEIGHT_LOADER_STRIDE_EN to add addr_stride_i (row address step,
// latched on start); otherwise the address steps by 1 per row.
//
// state   | meaning
// S_IDLE  | waiting for start_i
// S_LOAD  | issuing BRAM reads, buffer draining into the FIFO
// S_DRAIN | all reads issued, waiting for the buffer to empty
// S_DONE  | one-cycle done_o pulse
module weight_loader #(
    parameter int ARRAY_W = 32,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    input  logic [ADDR_W-1:0]         num_rows_i,
`ifdef WEIGHT_LOADER_STRIDE_EN
    input  logic [ADDR_W-1:0]         addr_stride_i,
`endif
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      mem_rd_en_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic [ARRAY_W*DATA_W-1:0] mem_data_i,
    weight_loader_if.master           fifo
);
    localparam int ROW_W = ARRAY_W * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rows_q, addr_q, issued_q, sent_q, stride;
    logic [1:0]        occ_q;
    logic              inflight_q;
    logic [ROW_W-1:0]  head_q, tail_q;
    logic              start_acc, write_en, sending, pop, push, room, rd_en;

    assign start_acc = (state_q == S_IDLE) & start_i;
    assign sending   = write_en & (occ_q != 2'd0);
    assign pop       = sending & fifo.request;
    assign push      = inflight_q;
    // occ + inflight - pop < 2, rearranged to stay unsigned
    assign room      = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign rd_en     = (state_q == S_LOAD) & (issued_q < rows_q) & room;

    assign mem_rd_en_o       = rd_en;
    assign mem_addr_o        = addr_q;
    assign fifo.write_en     = write_en;
    assign fifo.sending_data = sending;
    assign fifo.data         = (occ_q != 2'd0) ? head_q : '0;

`ifdef WEIGHT_LOADER_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    // Address step captured with the rest of the command
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stride_q <= '0;
        end else if (start_acc) begin
            stride_q <= addr_stride_i;
        end
    end

    assign stride = stride_q;
`else
    assign stride = ADDR_W'(1);
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs; DRAIN counts this cycle's pop so done follows the last send directly
    always_comb begin
        state_d  = state_q;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        write_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (num_rows_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                busy_o   = 1'b1;
                write_en = 1'b1;
                if (issued_q == rows_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy_o   = 1'b1;
                write_en = 1'b1;
                if ((sent_q + ADDR_W'(pop)) == rows_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, read address walk and issued/sent counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_q     <= '0;
            addr_q     <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (start_acc) begin
                rows_q   <= num_rows_i;
                addr_q   <= base_addr_i;
                issued_q <= '0;
                sent_q   <= '0;
            end else begin
                if (rd_en) begin
                    addr_q   <= addr_q + stride;
                    issued_q <= issued_q + ADDR_W'(1);
                end
                if (pop) begin
                    sent_q <= sent_q + ADDR_W'(1);
                end
            end
        end
    end

    // Two-entry row buffer; head_q is the oldest row, tail_q the second
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_q <= mem_data_i;
                    else               tail_q <= mem_data_i;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= mem_data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= mem_data_i;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
